// File: rtl/trap_ctrl_pkg.sv
// Shared types for the trap sequencer: FSM states, irq codes,
// the mcause interrupt bit and the trap vector computation.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_TRAP,
    ST_MRET
  } trap_state_t;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  localparam logic [31:0] MCAUSE_IRQ = 32'h8000_0000;
  localparam logic [1:0]  MTVEC_VEC  = 2'd1;

  // Modes 2/3 fall through to direct.
  function automatic logic [31:0] trap_vector(
    input logic [29:0] base,
    input logic [1:0]  mode,
    input logic [31:0] cause
  );
    logic [31:0] tgt;
    tgt = {base, 2'b00};
    if (mode == MTVEC_VEC && cause[31])
      tgt = tgt + {25'd0, cause[4:0], 2'b00};
    return tgt;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR-side bundle of the trap sequencer.
// master: trap_ctrl (drives strobes); slave: CSR block.
interface trap_ctrl_if #(
  parameter int NUM_IRQ_BITS = 32
);
  logic                    csr_interrupt_en;
  logic [NUM_IRQ_BITS-1:0] csr_mie;
  logic [1:0]              csr_mtvec_mode;
  logic [29:0]             csr_mtvec_base;
  logic [31:0]             csr_mepc;
  logic                    csr_exception;
  logic [31:0]             csr_exception_cause;
  logic [31:0]             csr_exception_pc;
  logic                    csr_mret;

  modport master (
    input  csr_interrupt_en,
    input  csr_mie,
    input  csr_mtvec_mode,
    input  csr_mtvec_base,
    input  csr_mepc,
    output csr_exception,
    output csr_exception_cause,
    output csr_exception_pc,
    output csr_mret
  );

  modport slave (
    output csr_interrupt_en,
    output csr_mie,
    output csr_mtvec_mode,
    output csr_mtvec_base,
    output csr_mepc,
    input  csr_exception,
    input  csr_exception_cause,
    input  csr_exception_pc,
    input  csr_mret
  );
endinterface

// File: rtl/trap_ctrl_irq_sync.sv
// N-flop synchroniser for one async level interrupt line.
// Ports: clk, nrst (sync, active-low), d_i async in, q_o synced out.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!nrst)
      sync_q <= '0;
    else
      sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer ahead of the CSR block: arbitrates
// exc/mret/irq, drains the pipe, strobes CSR, drives redirect/flush.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int NUM_IRQ_BITS = 32
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    irq_ext,
  input  logic                    irq_timer,
  input  logic                    irq_soft,
  input  logic                    exc_req,
  input  logic [31:0]             exc_cause,
  input  logic [31:0]             exc_pc,
  input  logic                    mret_req,
  input  logic                    pipe_empty,
  input  logic [31:0]             resume_pc,
  trap_ctrl_if.master             csr,
  output logic [NUM_IRQ_BITS-1:0] mip_pending,
  output logic                    stall_fetch,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [31:0]             redirect_pc
);

  logic mei_s, mti_s, msi_s;

  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_mei (
    .clk (clk), .nrst (nrst),
    .d_i (irq_ext), .q_o (mei_s)
  );
  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_mti (
    .clk (clk), .nrst (nrst),
    .d_i (irq_timer), .q_o (mti_s)
  );
  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_msi (
    .clk (clk), .nrst (nrst),
    .d_i (irq_soft), .q_o (msi_s)
  );

  logic [NUM_IRQ_BITS-1:0] mip;
  logic [NUM_IRQ_BITS-1:0] masked;
  logic                    irq_take;
  logic [4:0]              irq_code;

  always_comb begin
    mip                 = '0;
    mip[int'(IRQ_MEI)] = mei_s;
    mip[int'(IRQ_MTI)] = mti_s;
    mip[int'(IRQ_MSI)] = msi_s;
  end

  assign mip_pending = mip;
  assign masked      = mip & csr.csr_mie;
  assign irq_take    = csr.csr_interrupt_en & (|masked);

  // Fixed priority MEI > MSI > MTI.
  always_comb begin
    irq_code = IRQ_MTI;
    if (masked[int'(IRQ_MEI)])
      irq_code = IRQ_MEI;
    else if (masked[int'(IRQ_MSI)])
      irq_code = IRQ_MSI;
  end

  trap_state_t state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (exc_req) begin
          cause_d = exc_cause;
          epc_d   = exc_pc;
          state_d = ST_TRAP;
        end else if (mret_req) begin
          state_d = ST_MRET;
        end else if (irq_take) begin
          cause_d = MCAUSE_IRQ | {27'd0, irq_code};
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Cause is frozen here; a late exception preempts it.
        if (exc_req) begin
          cause_d = exc_cause;
          epc_d   = exc_pc;
          state_d = ST_TRAP;
        end else if (!irq_take) begin
          state_d = ST_IDLE;
        end else if (pipe_empty) begin
          epc_d   = resume_pc;
          state_d = ST_TRAP;
        end
      end
      ST_TRAP: state_d = ST_IDLE;
      ST_MRET: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_fetch             = 1'b0;
    flush                   = 1'b0;
    redirect_valid          = 1'b0;
    redirect_pc             = '0;
    csr.csr_exception       = 1'b0;
    csr.csr_exception_cause = '0;
    csr.csr_exception_pc    = '0;
    csr.csr_mret            = 1'b0;
    unique case (state_q)
      ST_DRAIN: stall_fetch = 1'b1;
      ST_TRAP: begin
        csr.csr_exception       = 1'b1;
        csr.csr_exception_cause = cause_q;
        csr.csr_exception_pc    = epc_q;
        flush                   = 1'b1;
        redirect_valid          = 1'b1;
        redirect_pc             = trap_vector(
          csr.csr_mtvec_base, csr.csr_mtvec_mode, cause_q);
      end
      ST_MRET: begin
        csr.csr_mret   = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = csr.csr_mepc;
      end
      default: ;
    endcase
  end

endmodule
